// File: rtl/step_clock_ctrl_if.sv
// Purpose : bundles the button inputs and status/strobe outputs of step_clock_ctrl.
// Latency : n/a (wires only).
// Backpressure: none; buttons are levels, core_en is a strobe the core must take.
// Ports   : btn_run/btn_step/btn_fast (raw buttons), core_en, running, fast, pulse_count[15:0];
//           with BREAKPOINT_EN defined also pc[31:0], bp_addr[31:0], bp_valid, bp_hit.
interface step_clock_ctrl_if;
  logic        btn_run;
  logic        btn_step;
  logic        btn_fast;
  logic        core_en;
  logic        running;
  logic        fast;
  logic [15:0] pulse_count;
`ifdef BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;

  modport master (
    output btn_run, btn_step, btn_fast, pc, bp_addr, bp_valid,
    input  core_en, running, fast, pulse_count, bp_hit
  );
  modport slave (
    input  btn_run, btn_step, btn_fast, pc, bp_addr, bp_valid,
    output core_en, running, fast, pulse_count, bp_hit
  );
`else
  modport master (
    output btn_run, btn_step, btn_fast,
    input  core_en, running, fast, pulse_count
  );
  modport slave (
    input  btn_run, btn_step, btn_fast,
    output core_en, running, fast, pulse_count
  );
`endif
endinterface

// File: rtl/step_clock_ctrl.sv
// Purpose : run/pause/single-step controller producing the core clock-enable strobe.
// Latency : raw button edge -> press event 2+DEBOUNCE_CYCLES cycles, event -> FSM/core_en 1 cycle.
// Backpressure: none; core_en is a one-cycle strobe, buttons are sampled levels.
// Ports   : clk, reset (sync, active-high), ctrl (step_clock_ctrl_if.slave):
//           btn_run/btn_step/btn_fast in, core_en/running/fast/pulse_count out.
// Option  : define BREAKPOINT_EN to add pc/bp_addr/bp_valid inputs and bp_hit output.
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SLOW_DIV        = 12000000,
  parameter int FAST_DIV        = 1200000,
  parameter int CNT_W           = 24
) (
  input  logic             clk,
  input  logic             reset,
  step_clock_ctrl_if.slave ctrl
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  // Button bit positions inside the packed vectors below.
  localparam int B_RUN  = 0;
  localparam int B_STEP = 1;
  localparam int B_FAST = 2;

  // ---------------------------------------------------------------------------
  // Synchronise and debounce the three buttons
  // ---------------------------------------------------------------------------
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       db_q;
  logic [CNT_W-1:0] deb_cnt [3];
  logic [2:0]       press;

  assign raw = {ctrl.btn_fast, ctrl.btn_step, ctrl.btn_run};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 3; i++) begin
        // Any cycle agreeing with the accepted level restarts the count, so
        // only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips db.
        if (sync2[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          db[i]      <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign press = db & ~db_q;

  // ---------------------------------------------------------------------------
  // Run / pause / step FSM with rate divider
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] period_last;
  logic             div_done;
  logic             fast_q;
  logic             fast_nxt;
  logic             en_nxt;
  logic             bp_stop;
  logic             core_en_q;
  logic             running_q;
  logic [15:0]      pulse_cnt;

  assign period_last = fast_q ? FAST_LAST : SLOW_LAST;
  assign div_done    = (div_cnt == period_last);

`ifdef BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_hit_nxt;
  assign bp_stop = ctrl.bp_valid && (ctrl.pc == ctrl.bp_addr);
`else
  assign bp_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PAUSED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    en_nxt    = 1'b0;
    fast_nxt  = fast_q ^ press[B_FAST];
`ifdef BREAKPOINT_EN
    bp_hit_nxt = bp_hit_q;
`endif
    case (state)
      PAUSED: begin
        // Run wins over a simultaneous step; the step is dropped.
        if (press[B_RUN]) begin
          state_nxt = RUNNING;
          div_nxt   = '0;
`ifdef BREAKPOINT_EN
          bp_hit_nxt = 1'b0;
`endif
        end else if (press[B_STEP]) begin
          // Stepping never consults the breakpoint so a stopped program can
          // be stepped past the address it halted on.
          state_nxt = STEPPING;
          en_nxt    = 1'b1;
        end
      end
      RUNNING: begin
        if (press[B_RUN]) begin
          // Pausing on the same cycle the divider completes swallows that pulse.
          state_nxt = PAUSED;
        end else if (div_done) begin
          div_nxt = '0;
          // A rate change on the completing cycle discards the period too.
          if (!press[B_FAST]) begin
            if (bp_stop) begin
              state_nxt = PAUSED;
`ifdef BREAKPOINT_EN
              bp_hit_nxt = 1'b1;
`endif
            end else begin
              en_nxt = 1'b1;
            end
          end
        end else begin
          div_nxt = div_cnt + CNT_W'(1);
        end
      end
      STEPPING: begin
        state_nxt = PAUSED;
      end
      default: begin
        state_nxt = PAUSED;
      end
    endcase
    // Rate toggles restart the period from zero in every state.
    if (press[B_FAST]) begin
      div_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      fast_q    <= 1'b0;
      core_en_q <= 1'b0;
      running_q <= 1'b0;
      pulse_cnt <= '0;
`ifdef BREAKPOINT_EN
      bp_hit_q  <= 1'b0;
`endif
    end else begin
      div_cnt   <= div_nxt;
      fast_q    <= fast_nxt;
      core_en_q <= en_nxt;
      running_q <= (state_nxt == RUNNING);
      if (en_nxt) begin
        pulse_cnt <= pulse_cnt + 16'd1;
      end
`ifdef BREAKPOINT_EN
      bp_hit_q  <= bp_hit_nxt;
`endif
    end
  end

  assign ctrl.core_en     = core_en_q;
  assign ctrl.running     = running_q;
  assign ctrl.fast        = fast_q;
  assign ctrl.pulse_count = pulse_cnt;
`ifdef BREAKPOINT_EN
  assign ctrl.bp_hit      = bp_hit_q;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // Back-to-back strobes are only possible with a one-cycle period.
  a_no_double_en: assert property (@(posedge clk) disable iff (reset)
    (core_en_q && (SLOW_DIV > 1) && (FAST_DIV > 1)) |=> !core_en_q);

  a_running_tracks_state: assert property (@(posedge clk) disable iff (reset)
    running_q == (state == RUNNING));

endmodule

// File: tb/tb_step_clock_ctrl.sv
module tb_step_clock_ctrl;

  localparam int DEB = 4;
  localparam int SD  = 10;
  localparam int FD  = 3;

  localparam int M_PAUSED  = 0;
  localparam int M_RUNNING = 1;
  localparam int M_STEP    = 2;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   pulse_q[$];

  step_clock_ctrl_if bus();

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SLOW_DIV(SD),
    .FAST_DIV(FD),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctrl(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each button's accepted level flips once the synchronised
  // input has disagreed with it for DEB edges in a row; a press is the cycle
  // after the accepted level rose. The controller is modelled as "edges
  // elapsed since the period last restarted".
  // ---------------------------------------------------------------------------
  bit          cap0[3];
  bit          cap1[3];
  bit          mdb[3];
  bit          mdb_prev[3];
  bit          win[3][DEB];
  int          m_state;
  int          m_elapsed;
  bit          m_fast;
  bit          m_en;
  bit          m_bp;
  logic [15:0] m_count;

  task automatic model_step();
    bit raw[3];
    bit ev[3];
    bit s;
    bit all_diff;
    int per;
    raw[0] = bus.btn_run;
    raw[1] = bus.btn_step;
    raw[2] = bus.btn_fast;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        cap0[b] = 0; cap1[b] = 0; mdb[b] = 0; mdb_prev[b] = 0;
        for (int i = 0; i < DEB; i++) win[b][i] = 0;
      end
      m_state = M_PAUSED; m_elapsed = 0; m_fast = 0; m_en = 0; m_bp = 0; m_count = 0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = mdb[b] && !mdb_prev[b];
      s = cap1[b];
      cap1[b] = cap0[b];
      cap0[b] = raw[b];
      for (int i = DEB - 1; i > 0; i--) win[b][i] = win[b][i-1];
      win[b][0] = s;
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (win[b][i] == mdb[b]) all_diff = 0;
      mdb_prev[b] = mdb[b];
      if (all_diff) mdb[b] = !mdb[b];
    end
    per  = m_fast ? FD : SD;
    m_en = 0;
    case (m_state)
      M_PAUSED: begin
        if (ev[0]) begin m_state = M_RUNNING; m_elapsed = 0; m_bp = 0; end
        else if (ev[1]) begin m_state = M_STEP; m_en = 1; end
      end
      M_STEP: m_state = M_PAUSED;
      default: begin
        if (ev[0]) m_state = M_PAUSED;
        else begin
          m_elapsed++;
          if (m_elapsed == per && !ev[2]) begin
            m_elapsed = 0;
`ifdef BREAKPOINT_EN
            if (bus.bp_valid && bus.pc == bus.bp_addr) begin m_state = M_PAUSED; m_bp = 1; end
            else m_en = 1;
`else
            m_en = 1;
`endif
          end
        end
      end
    endcase
    if (ev[2]) begin m_fast = !m_fast; m_elapsed = 0; end
    if (m_en) m_count = m_count + 16'd1;
  endtask

  // Compare process: model advances on each edge, DUT checked 1 time unit later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step();
    #1;
    chk("core_en", bus.core_en, m_en);
    chk("running", bus.running, (m_state == M_RUNNING));
    chk("fast", bus.fast, m_fast);
    chk("pulse_count", bus.pulse_count, m_count);
`ifdef BREAKPOINT_EN
    chk("bp_hit", bus.bp_hit, m_bp);
`endif
    if (bus.core_en) pulse_q.push_back(cyc);
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic int pulses_in(int lo, int hi);
    int n = 0;
    foreach (pulse_q[i]) if (pulse_q[i] >= lo && pulse_q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int first_pulse_after(int t);
    foreach (pulse_q[i]) if (pulse_q[i] > t) return pulse_q[i];
    return -1;
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_run = v;
      1: bus.btn_step = v;
      default: bus.btn_fast = v;
    endcase
  endtask

  // Raw button goes high just after edge t0 and is released hold edges later.
  task automatic press(input int b, input int hold, output int t0);
    @(negedge clk);
    t0 = cyc;
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0, t1, t2, p1, p2, bad, last;
    cyc = 0; n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.btn_fast = 1'b0;
`ifdef BREAKPOINT_EN
    bus.pc = '0; bus.bp_addr = '0; bus.bp_valid = 1'b0;
`endif

    // Reset for three cycles, then idle.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_until(cyc + 100);
    chk("idle_pulses", pulses_in(0, cyc), 0);
    chk("idle_pulse_count", bus.pulse_count, 0);
    chk("idle_running", bus.running, 0);

    // A 3-cycle glitch on step is filtered; a held press steps exactly once.
    press(1, 3, t0);
    wait_until(t0 + 20);
    chk("glitch_no_pulse", pulses_in(t0, cyc), 0);
    press(1, 20, t0);
    wait_until(t0 + 30);
    chk("step_pulses", pulses_in(t0, t0 + 30), 1);
    chk("step_latency", first_pulse_after(t0) - t0, 7);
    chk("step_pulse_count", bus.pulse_count, 1);
    chk("step_running", bus.running, 0);

    // Run slow, switch to fast after five pulses, then pause.
    press(0, 8, t0);
    wait_until(t0 + 58);
    chk("run_running", bus.running, 1);
    chk("run_slow_count", pulses_in(t0 + 1, t0 + 58), 5);
    chk("run_first_pulse", first_pulse_after(t0) - t0, 17);
    chk("run_slow_gap", first_pulse_after(t0 + 17) - t0, 27);
    press(2, 8, t1);
    wait_until(t1 + 20);
    p1 = first_pulse_after(t1 + 7);
    p2 = first_pulse_after(p1);
    chk("fast_first_pulse", p1 - t1, 10);
    chk("fast_gap", p2 - p1, 3);
    chk("fast_flag", bus.fast, 1);
    press(0, 8, t2);
    wait_until(t2 + 40);
    chk("pause_no_pulse", pulses_in(t2 + 7, cyc), 0);
    chk("pause_running", bus.running, 0);
    chk("pause_pulse_total", bus.pulse_count, pulse_q.size());

    // Run and step in the same cycle: run wins, no step pulse.
    @(negedge clk);
    t0 = cyc;
    bus.btn_run = 1'b1; bus.btn_step = 1'b1;
    repeat (8) @(negedge clk);
    bus.btn_run = 1'b0; bus.btn_step = 1'b0;
    wait_until(t0 + 12);
    chk("runstep_running", bus.running, 1);
    chk("runstep_no_step_pulse", pulses_in(t0, t0 + 9), 0);
    // Step while running leaves the fast period untouched.
    press(1, 8, t1);
    wait_until(t1 + 30);
    bad = 0; last = -1;
    foreach (pulse_q[i]) begin
      if (pulse_q[i] > t1 && pulse_q[i] <= t1 + 30) begin
        if (last >= 0 && pulse_q[i] - last != 3) bad++;
        last = pulse_q[i];
      end
    end
    chk("run_step_gap_errors", bad, 0);
    chk("run_step_pulses", pulses_in(t1 + 1, t1 + 30), 10);

    // Reset mid-run at divider count 7.
    pulse_reset();
    press(0, 8, t0);
    wait_until(t0 + 14);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_core_en", bus.core_en, 0);
    chk("midreset_running", bus.running, 0);
    chk("midreset_fast", bus.fast, 0);
    chk("midreset_pulse_count", bus.pulse_count, 0);
    reset = 1'b0;
    wait_until(t0 + 60);
    chk("midreset_no_pulse", pulses_in(t0 + 15, cyc), 0);

`ifdef BREAKPOINT_EN
    // Breakpoint at 0x10 while the bench advances pc on each strobe.
    pulse_reset();
    bus.bp_addr = 32'h10; bus.bp_valid = 1'b1; bus.pc = '0;
    press(0, 8, t0);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.core_en) bus.pc = bus.pc + 32'd4;
    end
    chk("bp_hit_set", bus.bp_hit, 1);
    chk("bp_paused", bus.running, 0);
    chk("bp_pc", bus.pc, 32'h10);
    press(1, 8, t1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.core_en) bus.pc = bus.pc + 32'd4;
    end
    chk("bp_step_pulse", pulses_in(t1, t1 + 23), 1);
    press(0, 8, t2);
    wait_until(t2 + 9);
    chk("bp_hit_cleared", bus.bp_hit, 0);
    bus.bp_valid = 1'b0;
`endif

    // Random button activity with occasional resets, checked by the model.
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bus.btn_run = ~bus.btn_run;
      if ($urandom_range(0, 7) == 0) bus.btn_step = ~bus.btn_step;
      if ($urandom_range(0, 9) == 0) bus.btn_fast = ~bus.btn_fast;
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.btn_fast = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
